exec_wb_stage: RTL and testbench
================================

# exec_wb_stage

Execute/write-back stage of the 8-bit processor, directly upstream of the register file. It accepts one decoded instruction per cycle over a valid/ready handshake and drives the register-file read addresses. It computes the ALU result, including a multi-cycle shift-add multiply, and registers the result. The following cycle it drives the register-file write port (rw, RegWr, dataW), forwarding in-flight results to the next instruction.

## Interface
- AddressSize, 3, register address width (8 registers)
- WordSize, 8, datapath width
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept; transfer on in_valid && in_ready at rising clk
- in_op  in  4  opcode
- in_ra, in_rb, in_rw  in  AddressSize  source A, source B, destination
- in_imm  in  WordSize  immediate
- in_use_imm  in  1  operand B = in_imm instead of register
- ra, rb  out  AddressSize  register-file read addresses; combinational copies of in_ra/in_rb
- dataA, dataB  in  WordSize  register-file asynchronous read data
- rw  out  AddressSize  write address
- dataW  out  WordSize  write data
- RegWr  out  1  write enable, high for exactly one cycle per committed result
- flags  out  3  {N, Z, C}
- busy  out  1  multiply in progress

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 SHL (A << B[2:0]), 6 SHR logical (A >> B[2:0]), 7 MOV (B), 8 MUL (low WordSize bits of A*B), 9 CMP (A−B, flags only).
- Opcodes 10–15 are NOP: they are accepted, cause no write and leave flags unchanged.
- Operand bypass: if the WB register is valid with a write pending and wb_rw equals in_ra (resp. in_rb when !in_use_imm), the operand is wb_data, not dataA/dataB. This covers a write committing in the same cycle as the read.
- Result arithmetic is modulo 2^WordSize.
- C flag:
  - ADD: carry out.
  - SUB and CMP: borrow, i.e. A < B unsigned.
  - SHL: last bit shifted out. SHR: last bit shifted out. Shift by 0 gives C=0.
  - Logic ops and MOV: C=0.
  - MUL: 1 if any upper product bit is nonzero.
- Z = (result == 0). N = result MSB.
- Flags update at the same edge the result loads into the WB register. CMP updates flags without a write.
- FSM states:
  - IDLE: in_ready=1. Accepting a non-MUL loads the WB register at that edge. Accepting MUL latches the bypassed operands, clears the count and goes to MUL.
  - MUL: in_ready=0, busy=1. One shift-add step per cycle. At count==WordSize−1 the product loads the WB register and flags, and the FSM returns to IDLE.
- WB register: valid, wr_en, wb_rw, wb_data. valid is cleared every edge unless a new result loads.
- RegWr = valid && wr_en; rw = wb_rw; dataW = wb_data.

## Timing
- Non-MUL latency: accepted at edge k, RegWr high during cycle k→k+1, register file written at edge k+1. Throughput is 1 instruction per cycle.
- MUL: accepted at edge k, result loads at edge k+WordSize, RegWr high the following cycle. in_ready is low for WordSize cycles.
- A WB entry pending when MUL is accepted still commits in the next cycle.
- Back-to-back dependent instructions need no stall, because bypass covers the only hazard.
- Reset values: FSM IDLE, count 0, WB valid 0, RegWr 0, rw 0, dataW 0, flags 3'b000, busy 0.
- in_ready is 0 while rst is asserted and 1 in the first cycle after release.
- Reset mid-MUL aborts the multiply: no write occurs and flags return to 0.
- Reset while RegWr is high: RegWr drops asynchronously and the write is lost.
- in_valid with in_ready=0 is ignored, and the upstream holds the instruction.

## Structure
- Shared package exec_pkg: opcode localparams (OP_ADD … OP_CMP), flag bit indices (FLAG_C=0, FLAG_Z=1, FLAG_N=2), FSM state encoding.
- One combinational sub-module alu_comb (A, B, op → result, carry) for the single-cycle ops.
- The multiply datapath, FSM, bypass mux and WB register stay in exec_wb_stage.
- The bench instantiates exec_wb_stage with regFile as the register-file model.

## Test plan
- MOV r1 ← imm 0x05, then ADD r2 ← r1+r1 on the next cycle → bypass gives r2=0x0A; RegWr is high on two consecutive cycles; flags N=0, Z=0, C=0.
- ADD imm 0xFF + r0 holding 0x01 → dataW=0x00, flags Z=1, C=1, N=0.
- MUL 0x0C × 0x0B:
  - Expected: 0x84, N=1, C=0, and in_ready low 8 cycles.
  - Then MUL 0x10 × 0x10 → 0x00, Z=1, C=1.
- CMP 0x03 vs 0x05 → RegWr never asserts, flags N=1, Z=0, C=1. A following NOP leaves the flags unchanged.
- SHL 0x81 by 1 → 0x02, C=1. SHR 0x81 by 0 → 0x81, C=0, N=1.
- Assert rst 4 cycles into a MUL → RegWr stays 0, flags=0, busy=0. in_ready is 1 the first cycle after release, and the destination register is unchanged.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute/write-back stage.
// Contents:
//   - opcode encodings OP_ADD .. OP_CMP (10..15 decode as NOP)
//   - bit positions of the {N, Z, C} flags
//   - FSM state type for the stage controller
package exec_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/exec_wb_stage_alu.sv
// Combinational ALU for every single-cycle opcode.
// Ports:
//   a, b    operands (already bypassed by the caller)
//   op      opcode
//   result  low WordSize bits of the operation
//   carry   carry / borrow / last bit shifted out, 0 for logic ops and MOV
// MUL and NOP opcodes produce zero here; the caller ignores them.
module alu_comb #(
  parameter int WordSize = 8
) (
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [3:0]          op,
  output logic [WordSize-1:0] result,
  output logic                carry
);
  import exec_pkg::*;

  logic [2:0] shamt;

  assign shamt = b[2:0];

  // Shifts are done one bit wider than the word so the bit that falls off
  // the end lands in carry; a shift of zero therefore leaves carry at 0.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: {carry, result} = {1'b0, a} << shamt;
      OP_SHR: {result, carry} = {a, 1'b0} >> shamt;
      OP_MOV: result = b;
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage sitting directly upstream of the register file.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        instruction handshake
//   in_op, in_ra, in_rb,     decoded instruction fields
//   in_rw, in_imm, in_use_imm
//   ra, rb                   register-file read addresses (pass-through)
//   dataA, dataB             register-file asynchronous read data
//   rw, dataW, RegWr         register-file write port
//   flags                    {N, Z, C}
//   busy                     shift-add multiply in progress
module exec_wb_stage #(
  parameter int AddressSize = 3,
  parameter int WordSize    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic [AddressSize-1:0] in_ra,
  input  logic [AddressSize-1:0] in_rb,
  input  logic [AddressSize-1:0] in_rw,
  input  logic [WordSize-1:0]    in_imm,
  input  logic                   in_use_imm,
  output logic [AddressSize-1:0] ra,
  output logic [AddressSize-1:0] rb,
  input  logic [WordSize-1:0]    dataA,
  input  logic [WordSize-1:0]    dataB,
  output logic [AddressSize-1:0] rw,
  output logic [WordSize-1:0]    dataW,
  output logic                   RegWr,
  output logic [2:0]             flags,
  output logic                   busy
);
  import exec_pkg::*;

  localparam int CountWidth = (WordSize > 1) ? $clog2(WordSize) : 1;
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(WordSize - 1);

  state_t state, nextState;

  logic [CountWidth-1:0]   count;
  logic [2*WordSize-1:0]   mulAcc;
  logic [2*WordSize-1:0]   mulCand;
  logic [WordSize-1:0]     mulPlier;
  logic [AddressSize-1:0]  mulRw;
  logic [2*WordSize-1:0]   mulSum;
  logic [WordSize-1:0]     mulResult;
  logic                    mulCarry;

  logic                    wbValid;
  logic                    wbWrEn;
  logic [AddressSize-1:0]  wbRw;
  logic [WordSize-1:0]     wbData;
  logic [2:0]              flagsReg;

  logic                    wbPending;
  logic [WordSize-1:0]     opA;
  logic [WordSize-1:0]     opB;
  logic [WordSize-1:0]     aluResult;
  logic                    aluCarry;
  logic                    accept;
  logic                    isMul;
  logic                    isNop;
  logic                    isCmp;

  assign ra = in_ra;
  assign rb = in_rb;

  // The result sitting in the WB register is written to the register file
  // at the same edge this instruction is accepted, so the register file
  // still shows the old value; take the in-flight result instead.
  assign wbPending = wbValid && wbWrEn;
  assign opA = (wbPending && (wbRw == in_ra)) ? wbData : dataA;
  assign opB = in_use_imm ? in_imm :
               ((wbPending && (wbRw == in_rb)) ? wbData : dataB);

  alu_comb #(.WordSize(WordSize)) u_alu (
    .a      (opA),
    .b      (opB),
    .op     (in_op),
    .result (aluResult),
    .carry  (aluCarry)
  );

  assign accept = in_valid && in_ready;
  assign isMul  = (in_op == OP_MUL);
  assign isCmp  = (in_op == OP_CMP);
  assign isNop  = (in_op > OP_CMP);

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set. The final step's sum is the full product.
  assign mulSum    = mulAcc + (mulPlier[0] ? mulCand : '0);
  assign mulResult = mulSum[WordSize-1:0];
  assign mulCarry  = |mulSum[2*WordSize-1:WordSize];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs. in_ready is held low during reset so
  // nothing upstream believes a transfer happened.
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst && isMul) begin
          nextState = ST_MUL;
        end
      end
      ST_MUL: begin
        busy = 1'b1;
        if (count == LastCount) begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Multiply datapath, WB register and flags. The WB entry lives for exactly
  // one cycle unless a new result replaces it; NOPs leave everything alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      mulAcc   <= '0;
      mulCand  <= '0;
      mulPlier <= '0;
      mulRw    <= '0;
      wbValid  <= 1'b0;
      wbWrEn   <= 1'b0;
      wbRw     <= '0;
      wbData   <= '0;
      flagsReg <= 3'b000;
    end else begin
      wbValid <= 1'b0;
      if (state == ST_MUL) begin
        mulAcc   <= mulSum;
        mulCand  <= mulCand << 1;
        mulPlier <= mulPlier >> 1;
        count    <= count + 1'b1;
        if (count == LastCount) begin
          wbValid          <= 1'b1;
          wbWrEn           <= 1'b1;
          wbRw             <= mulRw;
          wbData           <= mulResult;
          flagsReg[FLAG_N] <= mulResult[WordSize-1];
          flagsReg[FLAG_Z] <= (mulResult == '0);
          flagsReg[FLAG_C] <= mulCarry;
        end
      end else if (accept) begin
        if (isMul) begin
          mulAcc   <= '0;
          mulCand  <= {{WordSize{1'b0}}, opA};
          mulPlier <= opB;
          mulRw    <= in_rw;
          count    <= '0;
        end else if (!isNop) begin
          wbValid          <= 1'b1;
          wbWrEn           <= !isCmp;
          wbRw             <= in_rw;
          wbData           <= aluResult;
          flagsReg[FLAG_N] <= aluResult[WordSize-1];
          flagsReg[FLAG_Z] <= (aluResult == '0);
          flagsReg[FLAG_C] <= aluCarry;
        end
      end
    end
  end

  assign RegWr = wbPending;
  assign rw    = wbRw;
  assign dataW = wbData;
  assign flags = flagsReg;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Self-checking bench for exec_wb_stage: directed scenarios plus randomized
// instruction streams checked against an architectural reference model.
module tb_exec_wb_stage;

  localparam int AW = 3;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [AW-1:0] in_ra = '0;
  logic [AW-1:0] in_rb = '0;
  logic [AW-1:0] in_rw = '0;
  logic [WW-1:0] in_imm = '0;
  logic          in_use_imm = 1'b0;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [WW-1:0] dataA;
  logic [WW-1:0] dataB;
  logic [AW-1:0] rw;
  logic [WW-1:0] dataW;
  logic          RegWr;
  logic [2:0]    flags;
  logic          busy;

  logic [WW-1:0] regFile [8] = '{default: 8'h00};

  int checkCount = 0;
  int passCount  = 0;

  int            modelRegs [8];
  int            modelFlags;
  logic          expWr;
  logic [2:0]    expRw;
  logic [7:0]    expData;
  logic [2:0]    expFlags;
  int            readyLowCycles;

  exec_wb_stage #(.AddressSize(AW), .WordSize(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_rw      (in_rw),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .ra         (ra),
    .rb         (rb),
    .dataA      (dataA),
    .dataB      (dataB),
    .rw         (rw),
    .dataW      (dataW),
    .RegWr      (RegWr),
    .flags      (flags),
    .busy       (busy)
  );

  // Register-file model: asynchronous read, write on the rising edge.
  assign dataA = regFile[ra];
  assign dataB = regFile[rb];

  always @(posedge clk) begin
    if (RegWr) regFile[rw] <= dataW;
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  // Architectural meaning of each opcode, in plain integer arithmetic.
  function automatic void refExec(input int op, input int a, input int b,
                                  output int res, output int carry);
    int s;
    s = b % 8;
    res = 0;
    carry = 0;
    case (op)
      0: begin res = a + b; carry = (res > 255) ? 1 : 0; end
      1, 9: begin res = a - b; carry = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = a << s; carry = (s != 0) ? ((a >> (8 - s)) & 1) : 0; end
      6: begin res = a >> s; carry = (s != 0) ? ((a >> (s - 1)) & 1) : 0; end
      7: res = b;
      8: begin res = a * b; carry = (res > 255) ? 1 : 0; end
      default: ;
    endcase
    res = res & 255;
  endfunction

  // Drives one instruction and returns at the falling edge after it was
  // accepted, with in_valid dropped (a following call re-raises it at once).
  task automatic sendInstr(input logic [3:0] op, input logic [2:0] sa,
                           input logic [2:0] sb, input logic [2:0] dst,
                           input logic [7:0] imm, input logic useImm);
    int waitCount;
    in_op = op;
    in_ra = sa;
    in_rb = sb;
    in_rw = dst;
    in_imm = imm;
    in_use_imm = useImm;
    in_valid = 1'b1;
    waitCount = 0;
    while (in_ready !== 1'b1 && waitCount < 40) begin
      @(negedge clk);
      waitCount++;
    end
    if (in_ready !== 1'b1) begin
      checkCount++;
      $display("[TB] FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Computes the expected outcome from the model, sends the instruction and
  // waits until its result is visible on the write port.
  task automatic runInstr(input logic [3:0] op, input logic [2:0] sa,
                          input logic [2:0] sb, input logic [2:0] dst,
                          input logic [7:0] imm, input logic useImm);
    int a, b, res, c;
    a = modelRegs[sa];
    b = useImm ? int'(imm) : modelRegs[sb];
    refExec(int'(op), a, b, res, c);
    expWr = (op <= 4'd8);
    expRw = dst;
    expData = res[7:0];
    if (op <= 4'd9) modelFlags = ((res >> 7) & 1) * 4 + ((res == 0) ? 2 : 0) + c;
    expFlags = modelFlags[2:0];
    if (expWr) modelRegs[dst] = res;
    sendInstr(op, sa, sb, dst, imm, useImm);
    readyLowCycles = 0;
    while (in_ready === 1'b0 && readyLowCycles < 40) begin
      readyLowCycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkCount++;
    if ({in_ready, RegWr, busy, rw, dataW, flags} !== 16'h0000) begin
      $display("[TB] FAIL reset_state ready/wr/busy/rw/dataW/flags=%b required all 0",
               {in_ready, RegWr, busy, rw, dataW, flags});
    end else passCount++;
    rst = 1'b0;
    #1;
    checkCount++;
    if (in_ready !== 1'b1) begin
      $display("[TB] FAIL reset_release_ready got %b required 1", in_ready);
    end else passCount++;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    runInstr(4'd7, 3'd0, 3'd0, 3'd1, 8'h05, 1'b1);
    checkCount++;
    if ({RegWr, rw, dataW, flags} !== {1'b1, 3'd1, 8'h05, 3'b000}) begin
      $display("[TB] FAIL bypass_mov got wr=%b rw=%0d data=%h flags=%b required 1/1/05/000",
               RegWr, rw, dataW, flags);
    end else passCount++;
    runInstr(4'd0, 3'd1, 3'd1, 3'd2, 8'h00, 1'b0);
    checkCount++;
    if ({RegWr, rw, dataW, flags} !== {1'b1, 3'd2, 8'h0A, 3'b000}) begin
      $display("[TB] FAIL bypass_add got wr=%b rw=%0d data=%h flags=%b required 1/2/0a/000",
               RegWr, rw, dataW, flags);
    end else passCount++;
    @(negedge clk);
    checkCount++;
    if (RegWr !== 1'b0) begin
      $display("[TB] FAIL bypass_idle_wr got %b required 0", RegWr);
    end else passCount++;
  endtask

  task automatic test_add_carry();
    runInstr(4'd7, 3'd0, 3'd0, 3'd0, 8'h01, 1'b1);
    runInstr(4'd0, 3'd0, 3'd0, 3'd3, 8'hFF, 1'b1);
    checkCount++;
    if ({RegWr, dataW, flags} !== {1'b1, 8'h00, 3'b011}) begin
      $display("[TB] FAIL add_carry got wr=%b data=%h flags=%b required 1/00/011",
               RegWr, dataW, flags);
    end else passCount++;
  endtask

  task automatic test_mul();
    runInstr(4'd7, 3'd0, 3'd0, 3'd3, 8'h0C, 1'b1);
    runInstr(4'd7, 3'd0, 3'd0, 3'd4, 8'h0B, 1'b1);
    runInstr(4'd8, 3'd3, 3'd4, 3'd5, 8'h00, 1'b0);
    checkCount++;
    if (readyLowCycles !== 8) begin
      $display("[TB] FAIL mul_ready_low got %0d cycles required 8", readyLowCycles);
    end else passCount++;
    checkCount++;
    if ({RegWr, rw, dataW, flags} !== {1'b1, 3'd5, 8'h84, 3'b100}) begin
      $display("[TB] FAIL mul_0c_0b got wr=%b rw=%0d data=%h flags=%b required 1/5/84/100",
               RegWr, rw, dataW, flags);
    end else passCount++;
    checkCount++;
    if (regFile[4] !== 8'h0B) begin
      $display("[TB] FAIL mul_pending_commit got r4=%h required 0b", regFile[4]);
    end else passCount++;
    runInstr(4'd7, 3'd0, 3'd0, 3'd6, 8'h10, 1'b1);
    runInstr(4'd8, 3'd6, 3'd0, 3'd7, 8'h10, 1'b1);
    checkCount++;
    if ({RegWr, dataW, flags} !== {1'b1, 8'h00, 3'b011}) begin
      $display("[TB] FAIL mul_10_10 got wr=%b data=%h flags=%b required 1/00/011",
               RegWr, dataW, flags);
    end else passCount++;
  endtask

  task automatic test_cmp_nop();
    runInstr(4'd7, 3'd0, 3'd0, 3'd1, 8'h03, 1'b1);
    runInstr(4'd9, 3'd1, 3'd0, 3'd2, 8'h05, 1'b1);
    checkCount++;
    if ({RegWr, flags} !== {1'b0, 3'b101}) begin
      $display("[TB] FAIL cmp_flags got wr=%b flags=%b required 0/101", RegWr, flags);
    end else passCount++;
    runInstr(4'd12, 3'd1, 3'd1, 3'd2, 8'h00, 1'b0);
    checkCount++;
    if ({RegWr, flags} !== {1'b0, 3'b101}) begin
      $display("[TB] FAIL nop_flags got wr=%b flags=%b required 0/101", RegWr, flags);
    end else passCount++;
    @(negedge clk);
    checkCount++;
    if (regFile[2] !== 8'h0A) begin
      $display("[TB] FAIL cmp_no_write got r2=%h required 0a", regFile[2]);
    end else passCount++;
  endtask

  task automatic test_shifts();
    runInstr(4'd7, 3'd0, 3'd0, 3'd2, 8'h81, 1'b1);
    runInstr(4'd5, 3'd2, 3'd0, 3'd3, 8'h01, 1'b1);
    checkCount++;
    if ({RegWr, dataW, flags} !== {1'b1, 8'h02, 3'b001}) begin
      $display("[TB] FAIL shl_by_1 got wr=%b data=%h flags=%b required 1/02/001",
               RegWr, dataW, flags);
    end else passCount++;
    runInstr(4'd6, 3'd2, 3'd0, 3'd4, 8'h00, 1'b1);
    checkCount++;
    if ({RegWr, dataW, flags} !== {1'b1, 8'h81, 3'b100}) begin
      $display("[TB] FAIL shr_by_0 got wr=%b data=%h flags=%b required 1/81/100",
               RegWr, dataW, flags);
    end else passCount++;
  endtask

  task automatic test_reset_mid_mul();
    logic sawWrite;
    runInstr(4'd7, 3'd0, 3'd0, 3'd5, 8'h33, 1'b1);
    runInstr(4'd7, 3'd0, 3'd0, 3'd6, 8'h03, 1'b1);
    runInstr(4'd7, 3'd0, 3'd0, 3'd7, 8'h80, 1'b1);
    sendInstr(4'd8, 3'd6, 3'd7, 3'd5, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    modelFlags = 0;
    #1;
    checkCount++;
    if ({RegWr, flags, busy, in_ready} !== 6'b000000) begin
      $display("[TB] FAIL reset_mid_mul got wr=%b flags=%b busy=%b ready=%b required all 0",
               RegWr, flags, busy, in_ready);
    end else passCount++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkCount++;
    if (in_ready !== 1'b1) begin
      $display("[TB] FAIL reset_mid_mul_ready got %b required 1", in_ready);
    end else passCount++;
    sawWrite = 1'b0;
    repeat (12) begin
      @(negedge clk);
      sawWrite = sawWrite | RegWr;
    end
    checkCount++;
    if (sawWrite !== 1'b0) begin
      $display("[TB] FAIL reset_mid_mul_nowrite got RegWr seen=%b required 0", sawWrite);
    end else passCount++;
    checkCount++;
    if (regFile[5] !== 8'h33) begin
      $display("[TB] FAIL reset_mid_mul_dest got r5=%h required 33", regFile[5]);
    end else passCount++;
  endtask

  task automatic test_reset_during_write();
    logic [7:0] oldValue;
    oldValue = modelRegs[0][7:0];
    sendInstr(4'd7, 3'd0, 3'd0, 3'd0, 8'h55, 1'b1);
    checkCount++;
    if (RegWr !== 1'b1) begin
      $display("[TB] FAIL write_before_reset got RegWr=%b required 1", RegWr);
    end else passCount++;
    rst = 1'b1;
    modelFlags = 0;
    #1;
    checkCount++;
    if (RegWr !== 1'b0) begin
      $display("[TB] FAIL reset_drops_wr got RegWr=%b required 0", RegWr);
    end else passCount++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (regFile[0] !== oldValue) begin
      $display("[TB] FAIL reset_write_lost got r0=%h required %h", regFile[0], oldValue);
    end else passCount++;
  endtask

  task automatic test_random();
    int errors;
    logic [3:0] op;
    for (int r = 0; r < 8; r++) begin
      runInstr(4'd7, 3'd0, 3'd0, 3'(r), 8'($urandom_range(0, 255)), 1'b1);
    end
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      if (n % 5 == 0) op = 4'd8;
      runInstr(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
      if (op == 4'd8) begin
        checkCount++;
        if (readyLowCycles !== 8) begin
          $display("[TB] FAIL rand_mul_ready_low[%0d] got %0d required 8", n, readyLowCycles);
        end else passCount++;
      end
      checkCount++;
      if (expWr) begin
        if ({RegWr, rw, dataW, flags} !== {1'b1, expRw, expData, expFlags}) begin
          $display("[TB] FAIL rand_write[%0d] op=%0d got wr=%b rw=%0d data=%h flags=%b required 1/%0d/%h/%b",
                   n, op, RegWr, rw, dataW, flags, expRw, expData, expFlags);
        end else passCount++;
      end else begin
        if ({RegWr, flags} !== {1'b0, expFlags}) begin
          $display("[TB] FAIL rand_nowrite[%0d] op=%0d got wr=%b flags=%b required 0/%b",
                   n, op, RegWr, flags, expFlags);
        end else passCount++;
      end
    end
    @(negedge clk);
    errors = 0;
    for (int r = 0; r < 8; r++) begin
      if (regFile[r] !== modelRegs[r][7:0]) errors++;
    end
    checkCount++;
    if (errors != 0) begin
      $display("[TB] FAIL rand_regfile got %0d differing registers required 0", errors);
    end else passCount++;
  endtask

  initial begin
    for (int r = 0; r < 8; r++) modelRegs[r] = 0;
    modelFlags = 0;
    test_reset();
    test_bypass();
    test_add_carry();
    test_mul();
    test_cmp_nop();
    test_shifts();
    test_reset_mid_mul();
    test_reset_during_write();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
